// File: rtl/tage_table_assoc.sv
// Set-associative tagged TAGE component: registered lookup, single-cycle update/allocate,
// self-clearing init sweep and incremental useful-counter aging, one set per cycle.
module tage_table_assoc #(
    parameter int SETS     = 64,
    parameter int WAYS     = 2,
    parameter int TAG_SIZE = 8,
    parameter int CNT_SIZE = 3,
    parameter int USF_SIZE = 2,
    parameter int INTERVAL = 10,
    localparam int IDX_W   = $clog2(SETS),
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                OUT_ready,
    input  logic                IN_readValid,
    input  logic [IDX_W-1:0]    IN_readAddr,
    input  logic [TAG_SIZE-1:0] IN_readTag,
    output logic                OUT_readValid,
    output logic                OUT_readHit,
    output logic [WAY_W-1:0]    OUT_readWay,
    output logic                OUT_readTaken,
    input  logic                IN_writeValid,
    input  logic [IDX_W-1:0]    IN_writeAddr,
    input  logic [WAY_W-1:0]    IN_writeWay,
    input  logic [TAG_SIZE-1:0] IN_writeTag,
    input  logic                IN_writeTaken,
    input  logic                IN_writeUpdate,
    input  logic                IN_writeNew,
    input  logic                IN_writeUseful,
    input  logic                IN_anyAlloc,
    output logic                OUT_writeAlloc,
    output logic [WAY_W-1:0]    OUT_writeAllocWay
);

    typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, AGE = 2'd2} state_t;

    state_t               state_r;
    logic [IDX_W-1:0]     initPtr_r;
    logic [IDX_W-1:0]     agePtr_r;
    logic [INTERVAL-1:0]  decrCnt_r;

    logic                 entryValid_r  [SETS][WAYS];
    logic [TAG_SIZE-1:0]  entryTag_r    [SETS][WAYS];
    logic [USF_SIZE-1:0]  entryUseful_r [SETS][WAYS];
    logic [CNT_SIZE-1:0]  entryCnt_r    [SETS][WAYS];

    logic [WAYS-1:0]      matchVec_s;
    logic [WAYS-1:0]      freeVec_s;
    logic                 hit_s;
    logic [WAY_W-1:0]     hitWay_s;
    logic                 hitTaken_s;
    logic                 victimFound_s;
    logic [WAY_W-1:0]     victimWay_s;
    logic                 doUpdate_s;
    logic                 allocReq_s;
    logic                 decayAll_s;
    logic                 doAge_s;

    function automatic logic [CNT_SIZE-1:0] cntStep(input logic [CNT_SIZE-1:0] c, input logic up);
        logic [CNT_SIZE-1:0] r;
        if (up) r = (c == {CNT_SIZE{1'b1}}) ? c : c + CNT_SIZE'(1);
        else    r = (c == {CNT_SIZE{1'b0}}) ? c : c - CNT_SIZE'(1);
        return r;
    endfunction

    function automatic logic [USF_SIZE-1:0] usfStep(input logic [USF_SIZE-1:0] u, input logic up);
        logic [USF_SIZE-1:0] r;
        if (up) r = (u == {USF_SIZE{1'b1}}) ? u : u + USF_SIZE'(1);
        else    r = (u == {USF_SIZE{1'b0}}) ? u : u - USF_SIZE'(1);
        return r;
    endfunction

    // Tag match and victim search; the descending scan leaves the lowest matching way selected.
    always_comb begin
        matchVec_s  = {WAYS{1'b0}};
        freeVec_s   = {WAYS{1'b0}};
        hitWay_s    = {WAY_W{1'b0}};
        victimWay_s = {WAY_W{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            matchVec_s[w] = entryValid_r[IN_readAddr][w] && (entryTag_r[IN_readAddr][w] == IN_readTag);
            freeVec_s[w]  = !entryValid_r[IN_writeAddr][w] || (entryUseful_r[IN_writeAddr][w] == {USF_SIZE{1'b0}});
            hitWay_s      = matchVec_s[w] ? WAY_W'(w) : hitWay_s;
            victimWay_s   = freeVec_s[w] ? WAY_W'(w) : victimWay_s;
        end
        hit_s         = |matchVec_s;
        hitTaken_s    = hit_s & entryCnt_r[IN_readAddr][hitWay_s][CNT_SIZE-1];
        victimFound_s = |freeVec_s;
    end

    // Write-port decode; a write to the set being aged defers that set's aging by a cycle.
    always_comb begin
        doUpdate_s        = OUT_ready & IN_writeValid & IN_writeUpdate;
        allocReq_s        = OUT_ready & IN_writeValid & ~IN_writeUpdate & IN_writeNew;
        OUT_writeAlloc    = allocReq_s & victimFound_s;
        OUT_writeAllocWay = OUT_writeAlloc ? victimWay_s : {WAY_W{1'b0}};
        decayAll_s        = allocReq_s & ~victimFound_s & ~IN_anyAlloc;
        if (state_r == AGE) begin
            doAge_s = !((doUpdate_s | allocReq_s) && (IN_writeAddr == agePtr_r));
        end else begin
            doAge_s = 1'b0;
        end
    end

    // Entry storage: init clearing, update/allocate/decay writes, and per-set aging.
    always_ff @(posedge clk) begin
        if (state_r == INIT) begin
            for (int w = 0; w < WAYS; w++) begin
                entryValid_r[initPtr_r][w]  <= 1'b0;
                entryUseful_r[initPtr_r][w] <= {USF_SIZE{1'b0}};
                entryCnt_r[initPtr_r][w]    <= {CNT_SIZE{1'b0}};
            end
        end else begin
            if (doUpdate_s) begin
                entryCnt_r[IN_writeAddr][IN_writeWay]    <= cntStep(entryCnt_r[IN_writeAddr][IN_writeWay], IN_writeTaken);
                entryUseful_r[IN_writeAddr][IN_writeWay] <= usfStep(entryUseful_r[IN_writeAddr][IN_writeWay], IN_writeUseful);
            end else if (OUT_writeAlloc) begin
                entryValid_r[IN_writeAddr][victimWay_s]  <= 1'b1;
                entryTag_r[IN_writeAddr][victimWay_s]    <= IN_writeTag;
                entryUseful_r[IN_writeAddr][victimWay_s] <= {USF_SIZE{1'b0}};
                entryCnt_r[IN_writeAddr][victimWay_s]    <= IN_writeTaken ? {1'b1, {(CNT_SIZE-1){1'b0}}}
                                                                          : {1'b0, {(CNT_SIZE-1){1'b1}}};
            end else if (decayAll_s) begin
                for (int w = 0; w < WAYS; w++) begin
                    entryUseful_r[IN_writeAddr][w] <= usfStep(entryUseful_r[IN_writeAddr][w], 1'b0);
                end
            end
            if (doAge_s) begin
                for (int w = 0; w < WAYS; w++) begin
                    entryUseful_r[agePtr_r][w] <= usfStep(entryUseful_r[agePtr_r][w], 1'b0);
                end
            end
        end
    end

    // Control FSM (init sweep, idle interval, aging sweep) plus registered lookup outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= INIT;
            initPtr_r     <= {IDX_W{1'b0}};
            agePtr_r      <= {IDX_W{1'b0}};
            decrCnt_r     <= {INTERVAL{1'b0}};
            OUT_ready     <= 1'b0;
            OUT_readValid <= 1'b0;
            OUT_readHit   <= 1'b0;
            OUT_readWay   <= {WAY_W{1'b0}};
            OUT_readTaken <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    initPtr_r <= initPtr_r + IDX_W'(1);
                    if (initPtr_r == {IDX_W{1'b1}}) begin
                        state_r   <= IDLE;
                        OUT_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    decrCnt_r <= decrCnt_r + INTERVAL'(1);
                    if (decrCnt_r == {INTERVAL{1'b1}}) begin
                        state_r  <= AGE;
                        agePtr_r <= {IDX_W{1'b0}};
                    end
                end
                AGE: begin
                    if (doAge_s) begin
                        agePtr_r <= agePtr_r + IDX_W'(1);
                        if (agePtr_r == {IDX_W{1'b1}}) state_r <= IDLE;
                    end
                end
                default: begin
                    state_r   <= INIT;
                    initPtr_r <= {IDX_W{1'b0}};
                    OUT_ready <= 1'b0;
                end
            endcase
            OUT_readValid <= OUT_ready & IN_readValid;
            OUT_readHit   <= OUT_ready & IN_readValid & hit_s;
            OUT_readWay   <= (OUT_ready & IN_readValid & hit_s) ? hitWay_s : {WAY_W{1'b0}};
            OUT_readTaken <= OUT_ready & IN_readValid & hitTaken_s;
        end
    end

endmodule

// File: tb/tb_tage_table_assoc.sv
// Directed bench for tage_table_assoc: table-driven lookup/update/allocate vectors,
// then hand-written aging-sweep, write-collision and mid-aging reset sequences.
module tb_tage_table_assoc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       outReady, inReadValid, outReadValid, outReadHit, outReadWay, outReadTaken;
    logic [5:0] inReadAddr, inWriteAddr;
    logic [7:0] inReadTag, inWriteTag;
    logic       inWriteValid, inWriteWay, inWriteTaken, inWriteUpdate, inWriteNew, inWriteUseful, inAnyAlloc;
    logic       outWriteAlloc, outWriteAllocWay;

    int checks = 0;
    int errors = 0;
    int edgeCnt = 0;
    int rEdge = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    tage_table_assoc dut (
        .clk(clk), .rst_n(rst_n), .OUT_ready(outReady),
        .IN_readValid(inReadValid), .IN_readAddr(inReadAddr), .IN_readTag(inReadTag),
        .OUT_readValid(outReadValid), .OUT_readHit(outReadHit), .OUT_readWay(outReadWay),
        .OUT_readTaken(outReadTaken),
        .IN_writeValid(inWriteValid), .IN_writeAddr(inWriteAddr), .IN_writeWay(inWriteWay),
        .IN_writeTag(inWriteTag), .IN_writeTaken(inWriteTaken), .IN_writeUpdate(inWriteUpdate),
        .IN_writeNew(inWriteNew), .IN_writeUseful(inWriteUseful), .IN_anyAlloc(inAnyAlloc),
        .OUT_writeAlloc(outWriteAlloc), .OUT_writeAllocWay(outWriteAllocWay)
    );

    typedef struct {
        logic       doW, commit;
        logic [5:0] wAddr;
        logic       wWay;
        logic [7:0] wTag;
        logic       wTaken, wUpd, wNew, wUse, wAny, eAlloc, eAllocWay;
        logic [5:0] rAddr;
        logic [7:0] rTag;
        logic       eHit, eWay, eTaken;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        inReadValid = 1'b0; inReadAddr = 6'd0; inReadTag = 8'd0;
        inWriteValid = 1'b0; inWriteAddr = 6'd0; inWriteWay = 1'b0; inWriteTag = 8'd0;
        inWriteTaken = 1'b0; inWriteUpdate = 1'b0; inWriteNew = 1'b0; inWriteUseful = 1'b0;
        inAnyAlloc = 1'b0;
    endtask

    task automatic addV(input logic doW, cm, input logic [5:0] wa, input logic ww, input logic [7:0] wt,
                        input logic tk, upd, nw, us, any, eA, eAW,
                        input logic [5:0] ra, input logic [7:0] rt, input logic eH, eW, eT);
        vec_t v;
        v.doW = doW; v.commit = cm; v.wAddr = wa; v.wWay = ww; v.wTag = wt; v.wTaken = tk;
        v.wUpd = upd; v.wNew = nw; v.wUse = us; v.wAny = any; v.eAlloc = eA; v.eAllocWay = eAW;
        v.rAddr = ra; v.rTag = rt; v.eHit = eH; v.eWay = eW; v.eTaken = eT;
        vecs.push_back(v);
    endtask

    task automatic vUpd(input logic [5:0] a, input logic way, tk, us, input logic [7:0] rt, input logic eW, eT);
        addV(1'b1, 1'b1, a, way, 8'h00, tk, 1'b1, 1'b0, us, 1'b0, 1'b0, 1'b0, a, rt, 1'b1, eW, eT);
    endtask

    task automatic vAlloc(input logic [5:0] a, input logic [7:0] tag, input logic tk, any, cm, eA, eAW,
                          input logic [7:0] rt, input logic eH, eW, eT);
        addV(1'b1, cm, a, 1'b0, tag, tk, 1'b0, 1'b1, 1'b0, any, eA, eAW, a, rt, eH, eW, eT);
    endtask

    task automatic vRead(input logic [5:0] a, input logic [7:0] rt, input logic eH, eW, eT);
        addV(1'b0, 1'b0, a, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a, rt, eH, eW, eT);
    endtask

    // Counts negedges with OUT_ready low after reset release while poking both ports.
    task automatic waitReady(input string name);
        int   cnt = 0;
        logic bad = 1'b0;
        inReadValid = 1'b1; inWriteValid = 1'b1; inWriteNew = 1'b1;
        while (!outReady && cnt < 200) begin
            cnt++;
            if (outReadValid || outWriteAlloc) bad = 1'b1;
            @(negedge clk);
        end
        clearInputs();
        chk({name, ".readyCycles"}, cnt, 64);
        chk({name, ".quietInInit"}, bad, 1'b0);
        rEdge = edgeCnt;
    endtask

    task automatic doWr(input logic [5:0] a, input logic way, input logic [7:0] tag,
                        input logic tk, upd, nw, us, any);
        inWriteValid = 1'b1; inWriteAddr = a; inWriteWay = way; inWriteTag = tag; inWriteTaken = tk;
        inWriteUpdate = upd; inWriteNew = nw; inWriteUseful = us; inAnyAlloc = any;
        @(posedge clk); #1;
        clearInputs();
        @(negedge clk);
    endtask

    // Combinational allocation probe; inputs are withdrawn before the next clock edge.
    task automatic probe(input string name, input logic [5:0] a, input logic any, input logic eA, eW);
        inWriteValid = 1'b1; inWriteAddr = a; inWriteTag = 8'hEE; inWriteNew = 1'b1; inAnyAlloc = any;
        #1;
        chk({name, ".alloc"}, outWriteAlloc, eA);
        chk({name, ".allocWay"}, outWriteAllocWay, eW);
        clearInputs();
    endtask

    task automatic readChk(input string name, input logic [5:0] a, input logic [7:0] tag, input logic eH, eW, eT);
        inReadValid = 1'b1; inReadAddr = a; inReadTag = tag;
        @(posedge clk); #1;
        inReadValid = 1'b0;
        @(negedge clk);
        chk({name, ".valid"}, outReadValid, 1'b1);
        chk({name, ".hit"}, outReadHit, eH);
        chk({name, ".way"}, outReadWay, eW);
        chk({name, ".taken"}, outReadTaken, eT);
    endtask

    task automatic setupSet(input logic [5:0] a, input int u0, input int u1);
        doWr(a, 1'b0, 8'h50, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (u0) doWr(a, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        doWr(a, 1'b0, 8'h60, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (u1) doWr(a, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic waitEdge(input int n);
        while (edgeCnt < rEdge + n) @(negedge clk);
    endtask

    initial begin
        // Set 5: hit/miss, counter saturation both ends, useful saturation seen through victim choice.
        vAlloc(6'd5, 8'h3A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3A, 1'b1, 1'b0, 1'b1);
        vRead(6'd5, 8'h3B, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) vUpd(6'd5, 1'b0, 1'b0, 1'b0, 8'h3A, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) vUpd(6'd5, 1'b0, 1'b1, 1'b0, 8'h3A, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) vUpd(6'd5, 1'b0, 1'b1, 1'b0, 8'h3A, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) vUpd(6'd5, 1'b0, 1'b0, 1'b0, 8'h3A, 1'b0, 1'b1);
        vUpd(6'd5, 1'b0, 1'b0, 1'b0, 8'h3A, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) vUpd(6'd5, 1'b0, 1'b1, 1'b1, 8'h3A, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) vUpd(6'd5, 1'b0, 1'b0, 1'b0, 8'h3A, 1'b0, 1'b1);
        vAlloc(6'd5, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3A, 1'b1, 1'b0, 1'b1);
        vUpd(6'd5, 1'b0, 1'b0, 1'b0, 8'h3A, 1'b0, 1'b1);
        vAlloc(6'd5, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3A, 1'b1, 1'b0, 1'b1);
        // Set 9: no-victim decay gated by anyAlloc, replacement, multi-hit picks lowest way.
        vAlloc(6'd9, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
        vUpd(6'd9, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        vAlloc(6'd9, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1);
        vUpd(6'd9, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        vAlloc(6'd9, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
        vAlloc(6'd9, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
        vAlloc(6'd9, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1'b1);
        vAlloc(6'd9, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1);
        vRead(6'd9, 8'h11, 1'b0, 1'b0, 1'b0);
        vAlloc(6'd9, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0);

        clearInputs();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst.ready", outReady, 1'b0);
        chk("rst.readValid", outReadValid, 1'b0);
        chk("rst.readHit", outReadHit, 1'b0);
        chk("rst.readTaken", outReadTaken, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        waitReady("init1");

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            inWriteValid = v.doW; inWriteAddr = v.wAddr; inWriteWay = v.wWay; inWriteTag = v.wTag;
            inWriteTaken = v.wTaken; inWriteUpdate = v.wUpd; inWriteNew = v.wNew;
            inWriteUseful = v.wUse; inAnyAlloc = v.wAny;
            #1;
            if (v.doW) begin
                chk($sformatf("v%0d.alloc", i), outWriteAlloc, v.eAlloc);
                chk($sformatf("v%0d.allocWay", i), outWriteAllocWay, v.eAllocWay);
            end
            if (!v.commit) inWriteValid = 1'b0;
            @(posedge clk); #1;
            clearInputs();
            readChk($sformatf("v%0d", i), v.rAddr, v.rTag, v.eHit, v.eWay, v.eTaken);
        end

        // Aging sweep: 1024 idle cycles, then one set per cycle with a collision at set 30.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        waitReady("init2");
        setupSet(6'd5, 1, 1);
        setupSet(6'd20, 1, 1);
        setupSet(6'd30, 1, 2);
        setupSet(6'd31, 1, 1);
        waitEdge(1020);
        probe("preAge.s20", 6'd20, 1'b1, 1'b0, 1'b0);
        waitEdge(1029);
        probe("age.s5.before", 6'd5, 1'b1, 1'b0, 1'b0);
        waitEdge(1030);
        probe("age.s5.after", 6'd5, 1'b1, 1'b1, 1'b0);
        waitEdge(1054);
        doWr(6'd30, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        waitEdge(1056);
        probe("collide.s31.held", 6'd31, 1'b1, 1'b0, 1'b0);
        waitEdge(1057);
        probe("collide.s31.aged", 6'd31, 1'b1, 1'b1, 1'b0);
        waitEdge(1100);
        probe("collide.s30.both1", 6'd30, 1'b1, 1'b0, 1'b0);
        doWr(6'd30, 1'b0, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        probe("collide.s30.decayed", 6'd30, 1'b1, 1'b1, 1'b0);
        probe("postAge.s20", 6'd20, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of the second aging sweep.
        waitEdge(2139);
        readChk("midAge", 6'd20, 8'h50, 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("asyncRst.ready", outReady, 1'b0);
        chk("asyncRst.readValid", outReadValid, 1'b0);
        chk("asyncRst.readHit", outReadHit, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        waitReady("init3");
        readChk("postRst.s5", 6'd5, 8'h50, 1'b0, 1'b0, 1'b0);
        readChk("postRst.s20", 6'd20, 8'h60, 1'b0, 1'b0, 1'b0);
        readChk("postRst.s30", 6'd30, 8'h50, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
